// File: rtl/i2c_config_seq.sv
// I2C register-write sequencer: walks a configuration table and writes each
// entry ({DEV_ADDR, data bytes MSB first}) with START/STOP, ACK checks and retry.
module i2c_config_seq #(
  parameter int         QTR_DIV    = 256,
  parameter logic [7:0] DEV_ADDR   = 8'h34,
  parameter int         N_REGS     = 9,
  parameter int         IDX_W      = 4,
  parameter int         DATA_W     = 16,
  parameter int         MAX_RETRY  = 3,
  parameter int         AUTO_START = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  output logic [IDX_W-1:0]  rom_idx,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [IDX_W-1:0]  err_idx,
  output logic              i2c_scl,
  output logic              i2c_sda_oe,
  input  logic              i2c_sda_in
);

  localparam int QW   = $clog2(QTR_DIV);
  localparam int SH_W = 8 + DATA_W;
  localparam int NB   = 1 + DATA_W / 8;
  localparam int RW   = $clog2(MAX_RETRY + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_DONE, S_FAIL
  } state_t;

  state_t           r_state;
  logic [QW-1:0]    r_qcnt;
  logic [1:0]       r_q;
  logic [2:0]       r_bit;
  logic [2:0]       r_bytes;
  logic [SH_W-1:0]  r_sh;
  logic             r_nack;
  logic [RW-1:0]    r_retry;
  logic [IDX_W-1:0] r_rom_idx;
  logic [IDX_W-1:0] r_err_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_scl;
  logic             r_sda_oe;
  logic             r_sda_meta;
  logic             r_sda_sync;
  logic             r_auto_pend;
  logic             r_start_pend;

  logic w_tick;
  logic w_idle;
  logic w_trig;
  logic w_last;
  logic w_finish;

  assign w_tick   = (r_qcnt == QW'(QTR_DIV - 1));
  assign w_idle   = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_FAIL);
  assign w_trig   = w_idle && (start || r_start_pend || r_auto_pend);
  assign w_last   = (r_rom_idx == IDX_W'(N_REGS - 1));
  // Final STOP edge of the whole sequence (success or abort).
  assign w_finish = (r_state == S_STOP) && w_tick && (r_q == 2'd2) &&
                    (r_nack ? (r_retry == RW'(MAX_RETRY)) : w_last);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_qcnt <= '0;
    end else if (w_tick) begin
      r_qcnt <= '0;
    end else begin
      r_qcnt <= r_qcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
    end else begin
      r_sda_meta <= i2c_sda_in;
      r_sda_sync <= r_sda_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state      <= S_IDLE;
      r_q          <= '0;
      r_bit        <= '0;
      r_bytes      <= '0;
      r_sh         <= '0;
      r_nack       <= 1'b0;
      r_retry      <= '0;
      r_rom_idx    <= '0;
      r_err_idx    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_scl        <= 1'b1;
      r_sda_oe     <= 1'b0;
      r_auto_pend  <= (AUTO_START != 0);
      r_start_pend <= 1'b0;
    end else begin
      // A start coinciding with completion is replayed on the next cycle.
      r_start_pend <= start && w_finish;
      if (w_trig) begin
        r_auto_pend <= 1'b0;
        r_rom_idx   <= '0;
        r_retry     <= '0;
        r_done      <= 1'b0;
        r_err       <= 1'b0;
        r_busy      <= 1'b1;
        r_state     <= S_LOAD;
      end else begin
        case (r_state)
          S_LOAD: begin
            r_sh    <= {DEV_ADDR, rom_data};
            r_bytes <= 3'(NB);
            r_nack  <= 1'b0;
            r_q     <= '0;
            r_state <= S_START;
          end
          S_START: begin
            if (w_tick) begin
              if (r_q == 2'd0) begin
                r_sda_oe <= 1'b1;
                r_q      <= 2'd1;
              end else begin
                r_scl   <= 1'b0;
                r_q     <= 2'd0;
                r_bit   <= '0;
                r_state <= S_BIT;
              end
            end
          end
          S_BIT: begin
            if (w_tick) begin
              r_q <= r_q + 2'd1;
              case (r_q)
                2'd0: begin
                  r_sda_oe <= ~r_sh[SH_W-1];
                  r_scl    <= 1'b0;
                end
                2'd1: r_scl <= 1'b1;
                2'd2: begin
                end
                default: begin
                  r_scl <= 1'b0;
                  r_sh  <= r_sh << 1;
                  if (r_bit == 3'd7) begin
                    r_state <= S_ACK;
                  end else begin
                    r_bit <= r_bit + 3'd1;
                  end
                end
              endcase
            end
          end
          S_ACK: begin
            if (w_tick) begin
              r_q <= r_q + 2'd1;
              case (r_q)
                2'd0: r_sda_oe <= 1'b0;
                2'd1: r_scl    <= 1'b1;
                2'd2: r_nack   <= r_sda_sync;
                default: begin
                  r_scl <= 1'b0;
                  r_bit <= '0;
                  if (r_nack || (r_bytes == 3'd1)) begin
                    r_state <= S_STOP;
                  end else begin
                    r_bytes <= r_bytes - 3'd1;
                    r_state <= S_BIT;
                  end
                end
              endcase
            end
          end
          S_STOP: begin
            if (w_tick) begin
              case (r_q)
                2'd0: begin
                  r_sda_oe <= 1'b1;
                  r_q      <= 2'd1;
                end
                2'd1: begin
                  r_scl <= 1'b1;
                  r_q   <= 2'd2;
                end
                default: begin
                  r_sda_oe <= 1'b0;
                  r_q      <= 2'd0;
                  if (!r_nack) begin
                    r_retry <= '0;
                    if (w_last) begin
                      r_busy  <= 1'b0;
                      r_done  <= 1'b1;
                      r_state <= S_DONE;
                    end else begin
                      r_rom_idx <= r_rom_idx + 1'b1;
                      r_state   <= S_GAP;
                    end
                  end else if (r_retry < RW'(MAX_RETRY)) begin
                    r_retry <= r_retry + 1'b1;
                    r_state <= S_GAP;
                  end else begin
                    r_err     <= 1'b1;
                    r_err_idx <= r_rom_idx;
                    r_busy    <= 1'b0;
                    r_state   <= S_FAIL;
                  end
                end
              endcase
            end
          end
          S_GAP: begin
            if (w_tick) begin
              r_q <= r_q + 2'd1;
              if (r_q == 2'd3) begin
                r_state <= S_LOAD;
              end
            end
          end
          S_IDLE, S_DONE, S_FAIL: begin
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rom_idx    = r_rom_idx;
  assign err_idx    = r_err_idx;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign i2c_scl    = r_scl;
  assign i2c_sda_oe = r_sda_oe;

endmodule

// File: tb/tb_i2c_config_seq.sv
// Bench for i2c_config_seq: bus monitor + ACK/NACK slave, transactions checked
// against byte lists built from the table contents and the slave's NACK policy.
module tb_i2c_config_seq;

  localparam int         QD = 4;
  localparam logic [7:0] DA = 8'h34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst, start_a, start_b;
  logic [3:0]  rom_idx_a, err_idx_a, rom_idx_b, err_idx_b;
  logic [15:0] rom_data_a;
  logic [23:0] rom_data_b;
  logic        busy_a, done_a, err_a, scl_a, oe_a;
  logic        busy_b, done_b, err_b, scl_b, oe_b;
  logic        slave_oe = 1'b0;
  logic [15:0] tbl_a [2];
  logic [23:0] tbl_b;
  logic        scl_bus, sda_bus;

  assign scl_bus    = scl_a & scl_b;
  assign sda_bus    = ~(oe_a | oe_b | slave_oe);
  assign rom_data_a = (rom_idx_a < 4'd2) ? tbl_a[rom_idx_a[0]] : 16'h0;
  assign rom_data_b = tbl_b;

  i2c_config_seq #(.QTR_DIV(QD), .DEV_ADDR(DA), .N_REGS(2), .IDX_W(4), .DATA_W(16),
                   .MAX_RETRY(3), .AUTO_START(1)) dut_a (
    .clk(clk), .nrst(nrst), .start(start_a), .rom_idx(rom_idx_a), .rom_data(rom_data_a),
    .busy(busy_a), .done(done_a), .err(err_a), .err_idx(err_idx_a),
    .i2c_scl(scl_a), .i2c_sda_oe(oe_a), .i2c_sda_in(sda_bus));

  i2c_config_seq #(.QTR_DIV(QD), .DEV_ADDR(DA), .N_REGS(1), .IDX_W(4), .DATA_W(24),
                   .MAX_RETRY(3), .AUTO_START(0)) dut_b (
    .clk(clk), .nrst(nrst), .start(start_b), .rom_idx(rom_idx_b), .rom_data(rom_data_b),
    .busy(busy_b), .done(done_b), .err(err_b), .err_idx(err_idx_b),
    .i2c_scl(scl_b), .i2c_sda_oe(oe_b), .i2c_sda_in(sda_bus));

  int checks = 0;
  int failures = 0;

  // Decoded transactions (START..STOP): bytes packed MSB-first, ack bits LSB = last.
  logic [39:0] txn_data[$];
  int          txn_nb[$];
  logic [4:0]  txn_acks[$];
  int          rd_ptr = 0;

  logic        in_txn = 1'b0;
  int          cur_nb = 0;
  int          rise_cnt = 0;
  logic [39:0] cur_data = '0;
  logic [4:0]  cur_acks = '0;
  logic [7:0]  cur_byte = '0;
  int          nacks_given = 0;
  int          nack_pos = -1;
  int          nack_limit = 0;
  int          nack_base = 0;
  longint      cyc = 0;
  longint      hi_start = 0;
  int          last_hi = 0;
  logic        p_scl = 1'b1;
  logic        p_sda = 1'b1;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (p_scl && scl_bus && p_sda && !sda_bus) begin
      in_txn = 1'b1; cur_nb = 0; rise_cnt = 0; cur_data = '0; cur_acks = '0; cur_byte = '0;
      slave_oe = 1'b0;
    end else if (p_scl && scl_bus && !p_sda && sda_bus) begin
      if (in_txn) begin
        txn_data.push_back(cur_data);
        txn_nb.push_back(cur_nb);
        txn_acks.push_back(cur_acks);
      end
      in_txn = 1'b0;
      slave_oe = 1'b0;
    end else if (!p_scl && scl_bus && in_txn) begin
      hi_start = cyc;
      rise_cnt++;
      if (rise_cnt <= 8) begin
        cur_byte = {cur_byte[6:0], sda_bus};
      end else begin
        cur_data = {cur_data[31:0], cur_byte};
        cur_acks = {cur_acks[3:0], sda_bus};
        cur_nb++;
      end
    end else if (p_scl && !scl_bus && in_txn) begin
      last_hi = int'(cyc - hi_start);
      if (rise_cnt == 8) begin
        if (cur_nb == nack_pos && (nacks_given - nack_base) < nack_limit) begin
          slave_oe = 1'b0;
          nacks_given++;
        end else begin
          slave_oe = 1'b1;
        end
      end else if (rise_cnt == 9) begin
        slave_oe = 1'b0;
        rise_cnt = 0;
      end
    end
    p_scl = scl_bus;
    p_sda = sda_bus;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bytes on the wire for one entry: address then data MSB byte first, cut after byte 'upto'-1.
  function automatic logic [39:0] model_bytes(input logic [31:0] data, input int nd, input int upto);
    logic [7:0]  b [5];
    logic [39:0] v;
    v = '0;
    b[0] = DA;
    for (int k = 1; k <= nd; k++) b[k] = data[(nd-k)*8 +: 8];
    for (int k = 0; k < upto; k++) v = (v << 8) | {32'h0, b[k]};
    return v;
  endfunction

  task automatic expect_txn(input string tag, input logic [31:0] data, input int nd, input int nack_at);
    int upto;
    logic [4:0] eacks;
    int n;
    upto  = (nack_at < 0) ? nd + 1 : nack_at + 1;
    eacks = (nack_at < 0) ? 5'b0 : 5'b1;
    n = 0;
    while (txn_nb.size() <= rd_ptr && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (txn_nb.size() > rd_ptr) else begin
      failures++;
      $error("FAIL %s_timeout observed=none expected=transaction", tag);
    end
    if (txn_nb.size() > rd_ptr) begin
      chk({tag, "_len"}, txn_nb[rd_ptr], upto);
      chk({tag, "_bytes"}, txn_data[rd_ptr], model_bytes(data, nd, upto));
      chk({tag, "_acks"}, txn_acks[rd_ptr], eacks);
      $display("txn %s: %0d bytes %h acks %b", tag, txn_nb[rd_ptr], txn_data[rd_ptr], txn_acks[rd_ptr]);
      rd_ptr++;
    end
  endtask

  task automatic wait_idle(input bit use_b, input string tag);
    int n;
    n = 0;
    while ((use_b ? busy_b : busy_a) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (!(use_b ? busy_b : busy_a)) else begin
      failures++;
      $error("FAIL %s observed=busy expected=idle", tag);
    end
  endtask

  task automatic pulse(input bit use_b);
    @(negedge clk);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    int n;
    nrst = 1'b0; start_a = 1'b0; start_b = 1'b0;
    tbl_a[0] = 16'h0C00; tbl_a[1] = 16'h0E41; tbl_b = 24'h123456;
    repeat (5) @(negedge clk);
    chk("rst_scl", scl_a, 1);      chk("rst_oe", oe_a, 0);
    chk("rst_busy", busy_a, 0);    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);      chk("rst_idx", rom_idx_a, 0);
    chk("rst_eidx", err_idx_a, 0); chk("rst_b_scl", scl_b, 1);
    chk("rst_b_oe", oe_b, 0);      chk("rst_b_eidx", err_idx_b, 0);
    nrst = 1'b1;
    @(negedge clk);
    chk("auto_busy", busy_a, 1);
    chk("b_no_auto", busy_b, 0);

    // Plain two-entry write
    expect_txn("t1_e0", 32'h0C00, 2, -1);
    expect_txn("t1_e1", 32'h0E41, 2, -1);
    wait_idle(0, "t1_wait");
    chk("t1_done", done_a, 1); chk("t1_err", err_a, 0); chk("t1_idx", rom_idx_a, 1);

    // Data byte of entry 1 NACKed twice, then accepted
    tbl_a[0] = 16'($urandom); tbl_a[1] = 16'($urandom);
    pulse(0);
    chk("t2_busy", busy_a, 1); chk("t2_done_clr", done_a, 0); chk("t2_idx", rom_idx_a, 0);
    expect_txn("t2_e0", 32'(tbl_a[0]), 2, -1);
    nack_base = nacks_given; nack_pos = 1; nack_limit = 2;
    expect_txn("t2_e1_try0", 32'(tbl_a[1]), 2, 1);
    expect_txn("t2_e1_try1", 32'(tbl_a[1]), 2, 1);
    expect_txn("t2_e1_try2", 32'(tbl_a[1]), 2, -1);
    wait_idle(0, "t2_wait");
    chk("t2_done", done_a, 1); chk("t2_err", err_a, 0);
    nack_limit = 0; nack_pos = -1;

    // Start while busy is ignored; start on the done-set edge is replayed next cycle
    tbl_a[0] = 16'($urandom); tbl_a[1] = 16'($urandom);
    pulse(0);
    chk("t4_busy", busy_a, 1);
    expect_txn("t4_e0", 32'(tbl_a[0]), 2, -1);
    repeat (3) @(negedge clk);
    pulse(0);
    chk("t4_ignored_busy", busy_a, 1);
    chk("t4_ignored_idx", rom_idx_a, 1);
    n = 0;
    while (!(in_txn && cur_nb == 3) && n < 5000) begin @(negedge clk); n++; end
    while (scl_bus && n < 5000) begin @(negedge clk); n++; end
    while (!scl_bus && n < 5000) begin @(negedge clk); n++; end
    chk("t4_poll_bound", (n < 5000), 1);
    repeat (QD - 1) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    chk("t4_edge_done", done_a, 1); chk("t4_edge_busy", busy_a, 0);
    @(posedge clk);
    #1;
    chk("t4_replay_busy", busy_a, 1); chk("t4_replay_done", done_a, 0);
    chk("t4_replay_idx", rom_idx_a, 0);
    expect_txn("t4_e1", 32'(tbl_a[1]), 2, -1);
    expect_txn("t4_r_e0", 32'(tbl_a[0]), 2, -1);
    expect_txn("t4_r_e1", 32'(tbl_a[1]), 2, -1);
    wait_idle(0, "t4_wait");
    chk("t4_done", done_a, 1);
    repeat (300) @(negedge clk);
    chk("t4_no_extra", txn_nb.size() - rd_ptr, 0);

    // Address permanently NACKed: 1 + MAX_RETRY attempts, then abort
    nack_base = nacks_given; nack_pos = 0; nack_limit = 1000;
    pulse(0);
    chk("t3_busy", busy_a, 1);
    for (int a = 0; a < 4; a++) expect_txn($sformatf("t3_try%0d", a), 32'(tbl_a[0]), 2, 0);
    wait_idle(0, "t3_wait");
    chk("t3_err", err_a, 1); chk("t3_eidx", err_idx_a, 0);
    chk("t3_done", done_a, 0); chk("t3_busy_lo", busy_a, 0);
    repeat (300) @(negedge clk);
    chk("t3_no_extra", txn_nb.size() - rd_ptr, 0);
    nack_limit = 0; nack_pos = -1;

    // Reset in the middle of a data bit, then automatic restart
    tbl_a[0] = 16'($urandom); tbl_a[1] = 16'($urandom);
    pulse(0);
    chk("t5_err_clr", err_a, 0); chk("t5_busy", busy_a, 1);
    n = 0;
    while (!(in_txn && cur_nb == 1 && rise_cnt == 3) && n < 5000) begin @(negedge clk); n++; end
    chk("t5_poll_bound", (n < 5000), 1);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_rst_scl", scl_a, 1); chk("t5_rst_oe", oe_a, 0); chk("t5_rst_busy", busy_a, 0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("t5_auto_busy", busy_a, 1); chk("t5_auto_idx", rom_idx_a, 0);
    rd_ptr = txn_nb.size();
    expect_txn("t5_e0", 32'(tbl_a[0]), 2, -1);
    expect_txn("t5_e1", 32'(tbl_a[1]), 2, -1);
    wait_idle(0, "t5_wait");
    chk("t5_done", done_a, 1);

    // 24-bit entries: four bytes per transaction, SCL high time check
    pulse(1);
    chk("t6_busy", busy_b, 1);
    expect_txn("t6_fixed", 32'h123456, 3, -1);
    chk("t6_scl_high", last_hi, 2 * QD);
    wait_idle(1, "t6_wait");
    chk("t6_done", done_b, 1); chk("t6_err", err_b, 0); chk("t6_idx", rom_idx_b, 0);
    tbl_b = 24'($urandom);
    pulse(1);
    expect_txn("t6_rand", 32'(tbl_b), 3, -1);
    wait_idle(1, "t6_wait2");
    chk("t6_done2", done_b, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
